hack_mem_system: RTL and testbench

//  Memory-side responder for the Hack CPU. Serves instruction=ROM[pc] and
//  inM=MEM[addressM], and commits outM on writeM. Includes a boot loader FSM

---
 rtl/hack_mem_system.sv | 176 +++++++++++++++++
 tb/tb_hack_mem_system.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_mem_system.sv
// Hack CPU memory responder: ROM fetch, RAM/screen/keyboard data map and a byte-stream boot loader.
// Optional feature macro: HACK_MEM_BUSERR_EN adds a sticky bus_err output for bad accesses.
module hack_mem_system #(
    parameter int          ROM_AW   = 15,
    parameter int          RAM_AW   = 14,
    parameter logic [15:0] SCR_BASE = 16'h4000,
    parameter logic [15:0] KBD_ADDR = 16'h6000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic [15:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic [15:0] instruction,
    output logic [15:0] inM,
    output logic        cpu_reset,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    input  logic [15:0] kbd,
    output logic [15:0] words_loaded
`ifdef HACK_MEM_BUSERR_EN
    ,
    output logic        bus_err
`endif
);
    localparam int ROM_DEPTH = 2 ** ROM_AW;
    localparam int RAM_DEPTH = 2 ** RAM_AW;
    localparam int SCR_DEPTH = 8192;

    typedef enum logic [1:0] {LD_HI, LD_LO, RUN} state_t;

    state_t            state_q, state_d;
    logic [ROM_AW-1:0] ld_addr_q, ld_addr_d;
    logic [15:0]       words_loaded_q, words_loaded_d;
    logic [7:0]        hi_latch_q, hi_latch_d;
    logic [15:0]       kbd_reg_q, kbd_reg_d;

    logic [15:0] rom_mem [ROM_DEPTH];
    logic [15:0] ram_mem [RAM_DEPTH];
    logic [15:0] scr_mem [SCR_DEPTH];

    logic        rom_we;
    logic [15:0] rom_wdata;
    logic        rom_full;
    logic        accept;
    logic        in_ram;
    logic        in_scr;
    logic        in_kbd;
    logic        mem_we;
    logic [15:0] scr_off;
    logic        unused_ok;

    assign rom_full     = (ld_addr_q == {ROM_AW{1'b1}});
    assign accept       = ld_valid && (state_q != RUN);
    assign cpu_reset    = (state_q != RUN);
    assign ld_ready     = (state_q != RUN);
    assign words_loaded = words_loaded_q;
    assign kbd_reg_d    = kbd;

    // The last ROM slot moves to RUN before ld_addr could wrap, so it saturates.
    always_comb begin
        state_d        = state_q;
        ld_addr_d      = ld_addr_q;
        words_loaded_d = words_loaded_q;
        hi_latch_d     = hi_latch_q;
        rom_we         = 1'b0;
        rom_wdata      = 16'h0000;
        case (state_q)
            LD_HI: begin
                if (accept) begin
                    hi_latch_d = ld_byte;
                    if (ld_last) begin
                        rom_we         = 1'b1;
                        rom_wdata      = {ld_byte, 8'h00};
                        ld_addr_d      = rom_full ? ld_addr_q : ld_addr_q + ROM_AW'(1);
                        words_loaded_d = words_loaded_q + 16'd1;
                        state_d        = RUN;
                    end else begin
                        state_d = LD_LO;
                    end
                end
            end
            LD_LO: begin
                if (accept) begin
                    rom_we         = 1'b1;
                    rom_wdata      = {hi_latch_q, ld_byte};
                    ld_addr_d      = rom_full ? ld_addr_q : ld_addr_q + ROM_AW'(1);
                    words_loaded_d = words_loaded_q + 16'd1;
                    state_d        = (ld_last || rom_full) ? RUN : LD_HI;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = LD_HI;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= LD_HI;
            ld_addr_q      <= '0;
            words_loaded_q <= 16'h0000;
            hi_latch_q     <= 8'h00;
            kbd_reg_q      <= 16'h0000;
        end else begin
            state_q        <= state_d;
            ld_addr_q      <= ld_addr_d;
            words_loaded_q <= words_loaded_d;
            hi_latch_q     <= hi_latch_d;
            kbd_reg_q      <= kbd_reg_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rom_we) begin
            rom_mem[ld_addr_q] <= rom_wdata;
        end
    end

    assign instruction = rom_mem[pc[ROM_AW-1:0]];

    assign scr_off = addressM - SCR_BASE;
    assign in_ram  = ({1'b0, addressM} < 17'(RAM_DEPTH));
    assign in_scr  = (addressM >= SCR_BASE) && (scr_off < 16'(SCR_DEPTH));
    assign in_kbd  = (addressM == KBD_ADDR);
    assign mem_we  = writeM && (state_q == RUN);

    assign unused_ok = &{1'b0, pc, scr_off};

    always_comb begin
        inM = 16'h0000;
        if (in_ram) begin
            inM = ram_mem[addressM[RAM_AW-1:0]];
        end else if (in_scr) begin
            inM = scr_mem[scr_off[12:0]];
        end else if (in_kbd) begin
            inM = kbd_reg_q;
        end
    end

    // Array reads are asynchronous, so a same-address read sees the old word until this edge.
    always_ff @(posedge clk) begin
        if (mem_we && in_ram) begin
            ram_mem[addressM[RAM_AW-1:0]] <= outM;
        end
        if (mem_we && !in_ram && in_scr) begin
            scr_mem[scr_off[12:0]] <= outM;
        end
    end

`ifdef HACK_MEM_BUSERR_EN
    logic bus_err_q, bus_err_d;

    always_comb begin
        bus_err_d = bus_err_q;
        if (state_q == RUN) begin
            if ((writeM && !(in_ram || in_scr)) || !(in_ram || in_scr || in_kbd)) begin
                bus_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`endif

endmodule

// File: tb/tb_hack_mem_system.sv
// Randomized self-checking bench for hack_mem_system with an address-map/loader reference model.
module tb_hack_mem_system;
    localparam int ROM_AW_TB = 4;
    localparam int ROM_DEPTH = 1 << ROM_AW_TB;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic [15:0] pc       = 16'h0000;
    logic [15:0] addressM = 16'h0000;
    logic [15:0] outM     = 16'h0000;
    logic        writeM   = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte  = 8'h00;
    logic        ld_last  = 1'b0;
    logic [15:0] kbd      = 16'h0000;
    logic [15:0] instruction;
    logic [15:0] inM;
    logic        cpu_reset;
    logic        ld_ready;
    logic [15:0] words_loaded;
`ifdef HACK_MEM_BUSERR_EN
    logic        bus_err;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [7:0]  prog_bytes [8] = '{8'h01, 8'h2C, 8'hEC, 8'h10, 8'h07, 8'hD0, 8'hE3, 8'h08};
    logic [15:0] prog_words [4] = '{16'h012C, 16'hEC10, 16'h07D0, 16'hE308};

    hack_mem_system #(.ROM_AW(ROM_AW_TB)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .addressM     (addressM),
        .outM         (outM),
        .writeM       (writeM),
        .instruction  (instruction),
        .inM          (inM),
        .cpu_reset    (cpu_reset),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_byte      (ld_byte),
        .ld_last      (ld_last),
        .kbd          (kbd),
        .words_loaded (words_loaded)
`ifdef HACK_MEM_BUSERR_EN
        ,
        .bus_err      (bus_err)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: loader as a word counter plus pending high byte, memory as sparse maps.
    bit          m_running = 1'b0;
    bit          m_have_hi = 1'b0;
    logic [7:0]  m_hi      = 8'h00;
    int          m_count   = 0;
    logic [15:0] m_kbd     = 16'h0000;
    logic [15:0] m_rom [int];
    logic [15:0] m_mem [int];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_running = 1'b0;
            m_have_hi = 1'b0;
            m_count   = 0;
            m_kbd     = 16'h0000;
        end else begin
            if (m_running && writeM && addressM < 16'h6000) begin
                m_mem[int'(addressM)] = outM;
            end
            if (!m_running && ld_valid) begin
                if (!m_have_hi) begin
                    if (ld_last) begin
                        m_rom[m_count] = {ld_byte, 8'h00};
                        m_count++;
                        m_running = 1'b1;
                    end else begin
                        m_hi      = ld_byte;
                        m_have_hi = 1'b1;
                    end
                end else begin
                    m_rom[m_count] = {m_hi, ld_byte};
                    m_count++;
                    m_have_hi = 1'b0;
                    if (ld_last || m_count == ROM_DEPTH) begin
                        m_running = 1'b1;
                    end
                end
            end
            m_kbd = kbd;
        end
    end

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        int idx;
        int a;
        check_output("cpu_reset", {15'd0, cpu_reset}, {15'd0, !m_running});
        check_output("ld_ready", {15'd0, ld_ready}, {15'd0, !m_running});
        check_output("words_loaded", words_loaded, 16'(m_count));
        idx = int'(pc) % ROM_DEPTH;
        if (m_rom.exists(idx)) begin
            check_output("instruction", instruction, m_rom[idx]);
        end
        a = int'(addressM);
        if (a < 'h6000) begin
            if (m_mem.exists(a)) begin
                check_output("inM_mapped", inM, m_mem[a]);
            end
        end else if (a == 'h6000) begin
            check_output("inM_kbd", inM, m_kbd);
        end else begin
            check_output("inM_unmapped", inM, 16'h0000);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        next_cycle();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [15:0] addr, input logic [15:0] data, input logic we);
        addressM = addr;
        outM     = data;
        writeM   = we;
        next_cycle();
        writeM   = 1'b0;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return 16'($urandom_range(0, 15));
            1:       return 16'h3FF0 + 16'($urandom_range(0, 15));
            2:       return 16'h4000 + 16'($urandom_range(0, 15));
            3:       return 16'h5FF0 + 16'($urandom_range(0, 15));
            4:       return 16'h6000;
            default: return 16'($urandom_range(16'h6001, 16'hFFFF));
        endcase
    endfunction

    initial begin
        #1;
        reset = 1'b1;
        next_cycle();
        next_cycle();
        check_output("rst_cpu_reset", {15'd0, cpu_reset}, 16'h0001);
        check_output("rst_ld_ready", {15'd0, ld_ready}, 16'h0001);
        check_output("rst_words", words_loaded, 16'h0000);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            send_byte(prog_bytes[i], 1'b0);
        end
        ld_valid = 1'b1;
        ld_byte  = prog_bytes[7];
        ld_last  = 1'b1;
        #1;
        check_output("cpu_reset_before_last", {15'd0, cpu_reset}, 16'h0001);
        next_cycle();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check_output("cpu_reset_after_last", {15'd0, cpu_reset}, 16'h0000);
        check_output("prog_words_loaded", words_loaded, 16'd4);
        for (int i = 0; i < 4; i++) begin
            pc = 16'(i);
            #1;
            check_output("prog_rom", instruction, prog_words[i]);
        end
        pc = 16'h0000;

        apply_stimulus(16'd2000, 16'd300, 1'b1);
        check_output("ram_readback", inM, 16'd300);
        addressM = 16'd2000;
        outM     = 16'd555;
        writeM   = 1'b1;
        #1;
        check_output("rdw_old_value", inM, 16'd300);
        next_cycle();
        writeM = 1'b0;
        check_output("rdw_new_value", inM, 16'd555);
        apply_stimulus(16'd2000, 16'd300, 1'b1);

        kbd      = 16'h0041;
        addressM = 16'h6000;
        next_cycle();
        check_output("kbd_sample", inM, 16'h0041);
        apply_stimulus(16'h6000, 16'h1234, 1'b1);
        check_output("kbd_write_ignored", inM, 16'h0041);

        apply_stimulus(16'h4005, 16'hFFFF, 1'b1);
        check_output("screen_readback", inM, 16'hFFFF);
        apply_stimulus(16'h7000, 16'hBEEF, 1'b1);
        check_output("unmapped_read", inM, 16'h0000);
        apply_stimulus(16'h3FFF, 16'h1111, 1'b1);
        check_output("ram_top", inM, 16'h1111);
        apply_stimulus(16'h5FFF, 16'h2222, 1'b1);
        check_output("screen_top", inM, 16'h2222);
        addressM = 16'h3FFF;
        #1;
        check_output("ram_top_kept", inM, 16'h1111);

        for (int i = 0; i < 400; i++) begin
            addressM = pick_addr();
            outM     = 16'($urandom);
            writeM   = 1'($urandom_range(0, 1));
            pc       = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                kbd = 16'($urandom);
            end
            next_cycle();
        end
        writeM = 1'b0;

        reset_pulse();
        addressM = 16'd2000;
        outM     = 16'hDEAD;
        writeM   = 1'b1;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        writeM = 1'b0;
        check_output("mid_load_words", words_loaded, 16'd1);
        #2;
        reset = 1'b1;
        #1;
        check_output("async_cpu_reset", {15'd0, cpu_reset}, 16'h0001);
        check_output("async_ld_ready", {15'd0, ld_ready}, 16'h0001);
        check_output("async_words", words_loaded, 16'h0000);
        check_output("ram_preserved", inM, 16'd300);
        next_cycle();
        reset = 1'b0;

        send_byte(8'hAB, 1'b1);
        pc = 16'h0000;
        #1;
        check_output("single_byte_words", words_loaded, 16'd1);
        check_output("single_byte_rom", instruction, 16'hAB00);
        check_output("single_byte_run", {15'd0, cpu_reset}, 16'h0000);

        reset_pulse();
        for (int i = 0; i < 2 * ROM_DEPTH; i++) begin
            send_byte(8'(i + 8'h40), 1'b0);
        end
        check_output("rom_full_words", words_loaded, 16'(ROM_DEPTH));
        check_output("rom_full_run", {15'd0, ld_ready}, 16'h0000);
        send_byte(8'h99, 1'b1);
        check_output("rom_full_ignored", words_loaded, 16'(ROM_DEPTH));

        for (int r = 0; r < 6; r++) begin
            int nbytes;
            reset_pulse();
            nbytes = $urandom_range(1, 2 * ROM_DEPTH - 1);
            for (int i = 0; i < nbytes; i++) begin
                while ($urandom_range(0, 2) == 0) begin
                    ld_byte = 8'($urandom);
                    next_cycle();
                end
                send_byte(8'($urandom), 1'(i == nbytes - 1));
            end
            for (int i = 0; i < ROM_DEPTH; i++) begin
                pc       = 16'(i);
                addressM = pick_addr();
                next_cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
